peripheral_wb_burst_master: RTL

PERIPHERAL_WB_BURST_MASTER -- requirements
Module: peripheral_wb_burst_master

---
 rtl/peripheral_wb_pkg.sv | 30 +++
 rtl/peripheral_wb_burst_master.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/peripheral_wb_pkg.sv
// Shared Wishbone constants, master FSM states and the burst next-address helper.
package peripheral_wb_pkg;

  localparam logic [2:0] CLASSIC      = 3'b000;
  localparam logic [2:0] CONST_BURST  = 3'b001;
  localparam logic [2:0] INC_BURST    = 3'b010;
  localparam logic [2:0] END_OF_BURST = 3'b111;

  localparam logic [1:0] LINEAR  = 2'b00;
  localparam logic [1:0] WRAP_4  = 2'b01;
  localparam logic [1:0] WRAP_8  = 2'b10;
  localparam logic [1:0] WRAP_16 = 2'b11;

  typedef enum logic [1:0] {IDLE, LOAD, BURST} mst_state_e;

  // Works on byte-address bits [5:0] only; bit 6 of the result is the carry
  // into the upper address bits, which only a linear burst can produce.
  function automatic logic [6:0] next_low(input logic [5:0] lo, input logic [1:0] bte);
    logic [6:0] n;
    n = {1'b0, lo};
    unique case (bte)
      WRAP_4:  n[3:2] = lo[3:2] + 2'd1;
      WRAP_8:  n[4:2] = lo[4:2] + 3'd1;
      WRAP_16: n[5:2] = lo[5:2] + 4'd1;
      default: n = {1'b0, lo} + 7'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/peripheral_wb_burst_master.sv
// Wishbone B4 burst initiator: one command = 1..MAX_BURST beats, linear or wrapping,
// with a single write-data holding register and unthrottled read-data output.
module peripheral_wb_burst_master
  import peripheral_wb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16,
  parameter int LW        = $clog2(MAX_BURST) + 1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_adr_i,
  input  logic [LW-1:0] cmd_len_i,
  input  logic [1:0]    cmd_bte_i,
  input  logic          wdat_valid_i,
  output logic          wdat_ready_o,
  input  logic [DW-1:0] wdat_i,
  input  logic [3:0]    wsel_i,
  output logic          rdat_valid_o,
  output logic [DW-1:0] rdat_o,
  output logic          done_o,
  output logic          err_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic [1:0]    wb_bte_o,
  output logic [2:0]    wb_cti_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic [DW-1:0] wb_dat_i
);

  mst_state_e    state, state_nxt;
  logic [LW-1:0] cnt;
  logic [LW-1:0] len;
  logic          beat_ok, beat_err, last, wr_take;
  logic [6:0]    lo_nxt;
  logic [AW-1:0] adr_nxt;

  assign len      = (cmd_len_i == '0) ? LW'(1) : cmd_len_i;
  assign beat_err = wb_stb_o & wb_err_i;
  assign beat_ok  = wb_stb_o & wb_ack_i & ~wb_err_i;
  assign last     = (cnt == LW'(1));
  assign lo_nxt   = next_low(wb_adr_o[5:0], wb_bte_o);
  assign adr_nxt  = {wb_adr_o[AW-1:6] + (AW-6)'(lo_nxt[6]), lo_nxt[5:0]};

  // The holding register also frees up in the cycle its beat is acked, so the
  // next word can be taken then and write beats stream without a stb gap.
  assign cmd_ready_o  = (state == IDLE);
  assign wdat_ready_o = (state == LOAD) |
                        ((state == BURST) & wb_we_o & beat_ok & ~last);
  assign wr_take      = wdat_valid_i & wdat_ready_o;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (cmd_valid_i) state_nxt = cmd_we_i ? LOAD : BURST;
      LOAD:  if (wr_take) state_nxt = BURST;
      BURST: if (beat_err || (beat_ok && last)) state_nxt = IDLE;
             else if (beat_ok && wb_we_o && !wr_take) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_cti_o     <= CLASSIC;
      wb_bte_o     <= LINEAR;
      wb_adr_o     <= '0;
      wb_sel_o     <= '0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      rdat_valid_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      rdat_valid_o <= 1'b0;
      unique case (state)
        IDLE: if (cmd_valid_i) begin
          wb_we_o  <= cmd_we_i;
          wb_adr_o <= cmd_adr_i;
          wb_bte_o <= cmd_bte_i;
          cnt      <= len;
          wb_cti_o <= (len == LW'(1)) ? CLASSIC : INC_BURST;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= ~cmd_we_i;
          if (!cmd_we_i) wb_sel_o <= 4'hF;
        end
        LOAD: if (wr_take) begin
          wb_sel_o <= wsel_i;
          wb_stb_o <= 1'b1;
        end
        BURST: begin
          if (beat_err) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            err_o    <= 1'b1;
            done_o   <= 1'b1;
          end else if (beat_ok) begin
            rdat_valid_o <= ~wb_we_o;
            if (last) begin
              wb_cyc_o <= 1'b0;
              wb_stb_o <= 1'b0;
              done_o   <= 1'b1;
            end else begin
              cnt      <= cnt - LW'(1);
              wb_adr_o <= adr_nxt;
              wb_cti_o <= (cnt == LW'(2)) ? END_OF_BURST : INC_BURST;
              // Write with no next word ready: park in LOAD with cyc held.
              if (wb_we_o) begin
                wb_stb_o <= wr_take;
                if (wr_take) wb_sel_o <= wsel_i;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wr_take) wb_dat_o <= wdat_i;
    if (beat_ok && !wb_we_o) rdat_o <= wb_dat_i;
  end

endmodule
